dram_burst_splitter: RTL and testbench
======================================

DRAM_BURST_SPLITTER -- requirements
Module: dram_burst_splitter

Interface
REQ-001 SHALL have parameter DataWidth, default 512, meaning beat width in bits (multiple of 8).
REQ-002 SHALL have parameter AddrWidth, default 64, meaning byte address width.
REQ-003 SHALL have parameter MaxInflightRd, default 16, meaning the cap on outstanding read beats (at least 1).
REQ-004 SHALL use one clock; reset is synchronous and active-high, with ports named as below.
REQ-005 SHALL have port clk_i, input, 1 bit, the clock.
REQ-006 SHALL have port rst_i, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have ports burst_valid_i (input, 1) and burst_ready_o (output, 1), the burst command handshake.
REQ-008 SHALL have ports burst_we_i (input, 1), burst_addr_i (input, AddrWidth) and burst_len_i (input, 8), meaning write flag, start byte address, and beats minus 1.
REQ-009 SHALL have ports wdata_valid_i (input, 1), wdata_ready_o (output, 1), wdata_i (input, DataWidth) and wstrb_i (input, DataWidth/8), the write-data stream.
REQ-010 SHALL have ports req_valid_o (output, 1), req_ready_i (input, 1), we_o (output, 1), addr_o (output, AddrWidth), wdata_o (output, DataWidth) and wstrb_o (output, DataWidth/8), the per-beat request to the simulated DRAM.
REQ-011 SHALL have port rd_rsp_fire_i, input, 1 bit, meaning a read response was accepted downstream (rsp_valid and rsp_ready both high).
REQ-012 SHALL have port idle_o, output, 1 bit, meaning the FSM is in IDLE and the in-flight read count is 0.

Function
REQ-013 SHALL implement the FSM states IDLE, READ and WRITE.
REQ-014 SHALL drive burst_ready_o high only in IDLE; a burst fire latches we, address and beat count and moves to WRITE if we is set, otherwise to READ.
REQ-015 SHALL present the first beat in the cycle after the burst fire (latency 1); each request fire advances addr by DataWidth/8 and decrements the beat count.
REQ-016 SHALL wrap address arithmetic modulo 2^AddrWidth with no boundary splitting.
REQ-017 SHALL, in WRITE, drive req_valid_o = wdata_valid_i, wdata_ready_o = req_ready_i, and pass wdata_o/wstrb_o combinationally from wdata_i/wstrb_i, with we_o=1.
REQ-018 SHALL, in READ, drive req_valid_o = (inflight < MaxInflightRd), we_o=0, wdata_o=0, wstrb_o=0 and wdata_ready_o=0.
REQ-019 SHALL return the FSM to IDLE in the cycle after the last beat fires, so consecutive bursts have one bubble cycle.
REQ-020 SHALL treat burst_len_i=0 as a single beat and 255 as 256 beats.
REQ-021 SHALL increment the in-flight read counter on a read request fire and decrement it on rd_rsp_fire_i; when both occur in the same cycle the counter SHALL stay unchanged.
REQ-022 SHALL ignore rd_rsp_fire_i when the counter is 0, leaving the counter at 0 (no underflow).
REQ-023 SHALL keep addr_o, we_o and req_valid_o stable while req_valid_o is high and req_ready_i is low.
REQ-024 SHALL accept no burst while in READ or WRITE; a burst arriving in that time waits.

Reset
REQ-025 SHALL, on rst_i, enter IDLE and clear the beat count and in-flight counter.
REQ-026 SHALL hold these output values during reset: req_valid_o=0, burst_ready_o=0, wdata_ready_o=0, addr_o=0, idle_o=0; burst_ready_o=1 and idle_o=1 SHALL follow in the first cycle after reset.
REQ-027 SHALL, when reset is asserted mid-burst, abandon the remaining beats; responses arriving after reset SHALL be absorbed by REQ-022.

Configuration
REQ-028 SHALL, with macro DRAM_BURST_SPLITTER_ASSERT_EN defined, compile in simulation assertions for: REQ-023 stability, rd_rsp_fire_i while the count is 0, and the counter exceeding MaxInflightRd.
REQ-029 SHALL, without DRAM_BURST_SPLITTER_ASSERT_EN, contain no assertion code; functional behaviour SHALL be identical with or without the macro.

Structure
REQ-030 SHALL place the FSM state enum, the 8-bit length typedef and the beat-bytes constant function in the shared package dram_sim_pkg.
REQ-031 SHALL implement the in-flight counter as the sub-module dram_inflight_cnt, with inc, dec, saturating-at-0, count output and at_max flag.

Verification
REQ-032 SHALL cover a read burst: addr 0x80000000, len 3, req_ready_i=1 -> 4 beats at 0x80000000/0x40/0x80/0xC0, we_o=0, in consecutive cycles starting at cycle N+1.
REQ-033 SHALL cover a write burst: len 1, wdata_valid_i gapped every other cycle -> 2 write fires only when wdata_valid_i=1, with data and strobe passed unchanged.
REQ-034 SHALL cover the in-flight cap: MaxInflightRd=2, read len 4, no responses -> req_valid_o drops after 2 beats; one rd_rsp_fire_i -> exactly one more beat issues.
REQ-035 SHALL cover simultaneous issue and retire: count=1, read fire and rd_rsp_fire_i in the same cycle -> count stays 1.
REQ-036 SHALL cover address wrap: addr 0xFFFFFFFFFFFFFFC0, len 1 -> second beat addr 0x0.
REQ-037 SHALL cover reset mid-burst: rst_i at beat 2 of len 7 -> req_valid_o=0 next cycle; burst_ready_o=1 and idle_o=1 the cycle after rst_i deasserts.

Source files
------------

// File: rtl/dram_sim_pkg.sv
// Shared types and helpers for the DRAM simulation request path.
package dram_sim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } fsm_state_e;

    // Burst length as carried on the command: beats minus one.
    typedef logic [7:0] burst_len_t;

    function automatic int unsigned beat_bytes(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/dram_inflight_cnt.sv
// Outstanding read beat counter; decrement is ignored at zero, at_max flags the cap.
module dram_inflight_cnt #(
    parameter int unsigned MaxCount = 16,
    parameter int unsigned CntWidth = $clog2(MaxCount + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] count_o,
    output logic                at_max_o
);

    logic dec_eff;

    assign dec_eff  = dec_i && (count_o != '0);
    assign at_max_o = (count_o >= CntWidth'(MaxCount));

    // Simultaneous issue and retire cancel out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (inc_i && !dec_eff) begin
            count_o <= count_o + CntWidth'(1);
        end else if (dec_eff && !inc_i) begin
            count_o <= count_o - CntWidth'(1);
        end
    end

endmodule

// File: rtl/dram_burst_splitter.sv
// Splits burst commands into per-beat DRAM requests with a read in-flight cap.
// Optional simulation assertions: define DRAM_BURST_SPLITTER_ASSERT_EN.
module dram_burst_splitter
    import dram_sim_pkg::*;
#(
    parameter int unsigned DataWidth     = 512,
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned MaxInflightRd = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   burst_valid_i,
    output logic                   burst_ready_o,
    input  logic                   burst_we_i,
    input  logic [AddrWidth-1:0]   burst_addr_i,
    input  logic [7:0]             burst_len_i,
    input  logic                   wdata_valid_i,
    output logic                   wdata_ready_o,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] wstrb_i,
    output logic                   req_valid_o,
    input  logic                   req_ready_i,
    output logic                   we_o,
    output logic [AddrWidth-1:0]   addr_o,
    output logic [DataWidth-1:0]   wdata_o,
    output logic [DataWidth/8-1:0] wstrb_o,
    input  logic                   rd_rsp_fire_i,
    output logic                   idle_o
);

    localparam int unsigned BeatBytes = beat_bytes(DataWidth);
    localparam int unsigned CntWidth  = $clog2(MaxInflightRd + 1);

    fsm_state_e            state_q;
    logic [AddrWidth-1:0]  addr_q;
    burst_len_t            beats_q;
    logic [CntWidth-1:0]   inflight;
    logic                  at_max;
    logic                  burst_fire;
    logic                  req_fire;
    logic                  rd_fire;

    assign burst_fire = burst_valid_i && burst_ready_o;
    assign req_fire   = req_valid_o && req_ready_i;
    assign rd_fire    = req_fire && (state_q == ST_READ);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            beats_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (burst_fire) begin
                        addr_q  <= burst_addr_i;
                        beats_q <= burst_len_i;
                        state_q <= burst_we_i ? ST_WRITE : ST_READ;
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (req_fire) begin
                        addr_q <= addr_q + AddrWidth'(BeatBytes);
                        // beats_q holds beats left minus one, so zero marks the last beat
                        if (beats_q == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            beats_q <= beats_q - 8'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held, even if state is already IDLE.
    always_comb begin
        burst_ready_o = 1'b0;
        req_valid_o   = 1'b0;
        wdata_ready_o = 1'b0;
        we_o          = 1'b0;
        addr_o        = '0;
        wdata_o       = '0;
        wstrb_o       = '0;
        idle_o        = 1'b0;
        if (!rst_i) begin
            addr_o = addr_q;
            idle_o = (state_q == ST_IDLE) && (inflight == '0);
            case (state_q)
                ST_IDLE:  burst_ready_o = 1'b1;
                ST_READ:  req_valid_o   = !at_max;
                ST_WRITE: begin
                    req_valid_o   = wdata_valid_i;
                    wdata_ready_o = req_ready_i;
                    we_o          = 1'b1;
                    wdata_o       = wdata_i;
                    wstrb_o       = wstrb_i;
                end
                default: ;
            endcase
        end
    end

    dram_inflight_cnt #(
        .MaxCount (MaxInflightRd),
        .CntWidth (CntWidth)
    ) u_inflight (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (rd_fire),
        .dec_i    (rd_rsp_fire_i),
        .count_o  (inflight),
        .at_max_o (at_max)
    );

`ifdef DRAM_BURST_SPLITTER_ASSERT_EN
    a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (req_valid_o && !req_ready_i) |=> (req_valid_o && $stable(addr_o) && $stable(we_o)));

    a_rsp_nonzero: assert property (@(posedge clk_i) disable iff (rst_i)
        rd_rsp_fire_i |-> (inflight != '0));

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        inflight <= CntWidth'(MaxInflightRd));
`endif

endmodule

// File: tb/tb_dram_burst_splitter.sv
// Scoreboard bench for dram_burst_splitter: directed corner cases plus randomized bursts.
module tb_dram_burst_splitter;

    typedef struct {
        logic         we;
        logic [63:0]  addr;
        logic [511:0] data;
        logic [63:0]  strb;
    } beat_t;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         burst_valid_i = 1'b0;
    logic         burst_ready_o;
    logic         burst_we_i = 1'b0;
    logic [63:0]  burst_addr_i = '0;
    logic [7:0]   burst_len_i = '0;
    logic         wdata_valid_i = 1'b0;
    logic         wdata_ready_o;
    logic [511:0] wdata_i = '0;
    logic [63:0]  wstrb_i = '0;
    logic         req_valid_o;
    logic         req_ready_i = 1'b0;
    logic         we_o;
    logic [63:0]  addr_o;
    logic [511:0] wdata_o;
    logic [63:0]  wstrb_o;
    logic         rd_rsp_fire_i = 1'b0;
    logic         idle_o;

    int    tests = 0;
    int    fails = 0;
    int    outstanding = 0;
    bit    rsp_en = 1'b0;
    bit    rsp_manual = 1'b0;
    beat_t exp_q[$];

    dram_burst_splitter #(
        .DataWidth     (512),
        .AddrWidth     (64),
        .MaxInflightRd (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .burst_valid_i (burst_valid_i),
        .burst_ready_o (burst_ready_o),
        .burst_we_i    (burst_we_i),
        .burst_addr_i  (burst_addr_i),
        .burst_len_i   (burst_len_i),
        .wdata_valid_i (wdata_valid_i),
        .wdata_ready_o (wdata_ready_o),
        .wdata_i       (wdata_i),
        .wstrb_i       (wstrb_i),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready_i),
        .we_o          (we_o),
        .addr_o        (addr_o),
        .wdata_o       (wdata_o),
        .wstrb_o       (wstrb_o),
        .rd_rsp_fire_i (rd_rsp_fire_i),
        .idle_o        (idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: beat i of a burst lands at start + i*64 bytes, modulo 2^64.
    task automatic push_reads(input logic [63:0] a, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.we   = 1'b0;
            b.addr = a + 64'(i) * 64'd64;
            b.data = '0;
            b.strb = '0;
            exp_q.push_back(b);
        end
    endtask

    // Response source: random while rsp_en, otherwise directly steered by rsp_manual.
    always @(posedge clk_i) begin
        #2;
        if (rsp_en) rd_rsp_fire_i = (outstanding > 0) && ($urandom_range(0, 2) == 0);
        else        rd_rsp_fire_i = rsp_manual;
    end

    // Monitor: every request fire is checked against the head of the scoreboard.
    always @(negedge clk_i) begin
        beat_t e;
        if (rst_i) begin
            exp_q.delete();
            outstanding = 0;
        end else begin
            if (req_valid_o && req_ready_i) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected: got addr %0h we %0b with no beat expected", addr_o, we_o);
                end else begin
                    e = exp_q.pop_front();
                    if (addr_o !== e.addr || we_o !== e.we || wdata_o !== e.data || wstrb_o !== e.strb) begin
                        fails++;
                        $display("FAIL beat: got addr %0h we %0b strb %0h dlo %0h expected addr %0h we %0b strb %0h dlo %0h",
                                 addr_o, we_o, wstrb_o, wdata_o[63:0], e.addr, e.we, e.strb, e.data[63:0]);
                    end
                end
                if (!we_o) outstanding++;
            end
            if (rd_rsp_fire_i && outstanding > 0) outstanding--;
        end
    end

    task automatic run_burst(input bit we, input logic [63:0] a, input logic [7:0] len, input bit gapped);
        logic [511:0] d[$];
        logic [63:0]  s[$];
        beat_t        b;
        int           n;
        int           bi;
        int           guard;
        bit           fired;
        n  = int'(len) + 1;
        bi = 0;
        for (int i = 0; i < n; i++) begin
            b.we   = we;
            b.addr = a + 64'(i) * 64'd64;
            b.data = we ? rand512() : '0;
            b.strb = we ? {$urandom, $urandom} : '0;
            exp_q.push_back(b);
            d.push_back(b.data);
            s.push_back(b.strb);
        end
        burst_valid_i = 1'b1;
        burst_we_i    = we;
        burst_addr_i  = a;
        burst_len_i   = len;
        guard = 0;
        while (1) begin
            @(negedge clk_i);
            if (burst_ready_o) break;
            guard++;
            if (guard > 4000) begin
                timeout_fail("burst_accept");
                burst_valid_i = 1'b0;
                return;
            end
            step();
        end
        step();
        burst_valid_i = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 4000) begin
            req_ready_i = gapped ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (we && bi < n) begin
                if (!wdata_valid_i) wdata_valid_i = gapped ? (guard % 2 == 0) : ($urandom_range(0, 2) != 0);
                wdata_i = d[bi];
                wstrb_i = s[bi];
            end
            @(negedge clk_i);
            if (we) begin
                chk("wr_valid_follow", 64'(req_valid_o), 64'(wdata_valid_i));
                chk("wr_ready_follow", 64'(wdata_ready_o), 64'(req_ready_i));
            end
            fired = wdata_valid_i && wdata_ready_o;
            step();
            if (fired) begin
                bi++;
                wdata_valid_i = 1'b0;
            end
            guard++;
        end
        if (exp_q.size() != 0) timeout_fail("burst_drain");
        wdata_valid_i = 1'b0;
        req_ready_i   = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (2) step();
        @(negedge clk_i);
        chk("rst_req_valid", 64'(req_valid_o), 0);
        chk("rst_burst_ready", 64'(burst_ready_o), 0);
        chk("rst_wdata_ready", 64'(wdata_ready_o), 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_idle", 64'(idle_o), 0);
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_burst_ready", 64'(burst_ready_o), 1);
        chk("post_rst_idle", 64'(idle_o), 1);
        step();

        // Read len 3 at 0x80000000, back-to-back beats with one response per cycle
        req_ready_i = 1'b1;
        push_reads(64'h8000_0000, 4);
        burst_valid_i = 1'b1; burst_we_i = 1'b0; burst_addr_i = 64'h8000_0000; burst_len_i = 8'd3;
        @(negedge clk_i);
        chk("rd_burst_ready", 64'(burst_ready_o), 1);
        step();
        burst_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("rd_beat_valid", 64'(req_valid_o), 1);
            chk("rd_beat_addr", addr_o, 64'h8000_0000 + 64'(i) * 64'd64);
            step();
            rsp_manual = 1'b1;
        end
        @(negedge clk_i);
        chk("rd_bubble_ready", 64'(burst_ready_o), 1);
        chk("rd_bubble_valid", 64'(req_valid_o), 0);
        chk("rd_bubble_not_idle", 64'(idle_o), 0);
        step();
        rsp_manual = 1'b0;
        @(negedge clk_i);
        chk("rd_drained_idle", 64'(idle_o), 1);
        step();

        // In-flight cap of 2, then simultaneous issue and retire at count 1
        push_reads(64'h1000, 5);
        burst_valid_i = 1'b1; burst_we_i = 1'b0; burst_addr_i = 64'h1000; burst_len_i = 8'd4;
        @(negedge clk_i);
        chk("cap_burst_ready", 64'(burst_ready_o), 1);
        step();
        burst_valid_i = 1'b0;
        @(negedge clk_i); chk("cap_beat1", 64'(req_valid_o), 1); step();
        @(negedge clk_i); chk("cap_beat2", 64'(req_valid_o), 1); step();
        @(negedge clk_i); chk("cap_stall", 64'(req_valid_o), 0); step();
        rsp_manual = 1'b1;
        @(negedge clk_i); chk("cap_stall2", 64'(req_valid_o), 0); step();
        rsp_manual = 1'b0;
        @(negedge clk_i); chk("cap_one_more", 64'(req_valid_o), 1); step();
        @(negedge clk_i); chk("cap_recap", 64'(req_valid_o), 0); step();
        rsp_manual = 1'b1;
        @(negedge clk_i); step();
        @(negedge clk_i); chk("simul_valid", 64'(req_valid_o), 1); step();
        rsp_manual = 1'b0;
        @(negedge clk_i); chk("simul_keep1", 64'(req_valid_o), 1); step();
        rsp_manual = 1'b1;
        @(negedge clk_i);
        chk("simul_back_idle", 64'(burst_ready_o), 1);
        chk("simul_cnt2_busy", 64'(idle_o), 0);
        step();
        rsp_manual = 1'b0;
        @(negedge clk_i); chk("simul_cnt1", 64'(idle_o), 0); step();
        rsp_manual = 1'b1;
        step();
        rsp_manual = 1'b0;
        @(negedge clk_i); chk("simul_cnt0", 64'(idle_o), 1); step();

        // Gapped write, address wrap, then random traffic
        run_burst(1'b1, 64'h0000_2000, 8'd1, 1'b1);
        rsp_en = 1'b1;
        run_burst(1'b0, 64'hFFFF_FFFF_FFFF_FFC0, 8'd1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            run_burst(1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom_range(0, 15)), 1'b0);
        end
        run_burst(1'b0, {$urandom, $urandom}, 8'd255, 1'b0);
        run_burst(1'b1, 64'hFFFF_FFFF_FFFF_FF00, 8'd7, 1'b0);

        // Reset in the middle of a read burst
        rsp_en = 1'b0;
        rsp_manual = 1'b0;
        repeat (40) step();
        req_ready_i = 1'b1;
        push_reads(64'h4000, 8);
        burst_valid_i = 1'b1; burst_we_i = 1'b0; burst_addr_i = 64'h4000; burst_len_i = 8'd7;
        @(negedge clk_i);
        chk("mid_rst_burst_ready", 64'(burst_ready_o), 1);
        step();
        burst_valid_i = 1'b0;
        @(negedge clk_i); chk("mid_rst_beat1", 64'(req_valid_o), 1); step();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("mid_rst_req_valid", 64'(req_valid_o), 0);
        chk("mid_rst_burst_ready", 64'(burst_ready_o), 0);
        chk("mid_rst_idle", 64'(idle_o), 0);
        chk("mid_rst_addr", addr_o, 0);
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("after_rst_req_valid", 64'(req_valid_o), 0);
        chk("after_rst_burst_ready", 64'(burst_ready_o), 1);
        chk("after_rst_idle", 64'(idle_o), 1);
        step();

        rsp_en = 1'b1;
        run_burst(1'b0, 64'h5000, 8'd2, 1'b0);
        run_burst(1'b1, 64'h6000, 8'd0, 1'b0);
        chk("scoreboard_empty", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
